// File: rtl/id_ex_if.sv
// id_ex_if: decode-side inputs and EX-side outputs of the ID/EX stage
interface id_ex_if #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic               Hold;
    logic               Flush;
    logic               ID_Valid;
    logic [REG_W-1:0]   ID_Dst;
    logic [REG_W-1:0]   ID_Src;
    logic               ID_UsesDst;
    logic               ID_UsesSrc;
    logic [DATA_W-1:0]  ID_Data_Dst;
    logic [DATA_W-1:0]  ID_Data_Src;
    logic               ID_WB;
    logic               ID_MemRead;
    logic               ID_MemWrite;
    logic [ALUOP_W-1:0] ID_ALUOp;
    logic               EX_Valid;
    logic [REG_W-1:0]   EX_Dst;
    logic [REG_W-1:0]   EX_Src;
    logic [DATA_W-1:0]  EX_Data_Dst;
    logic [DATA_W-1:0]  EX_Data_Src;
    logic               EX_WB;
    logic               EX_MemRead;
    logic               EX_MemWrite;
    logic [ALUOP_W-1:0] EX_ALUOp;
    logic               Stall;
    logic [CNT_W-1:0]   Bubble_Count;

    modport master (
        output Hold, Flush, ID_Valid, ID_Dst, ID_Src, ID_UsesDst, ID_UsesSrc,
               ID_Data_Dst, ID_Data_Src, ID_WB, ID_MemRead, ID_MemWrite, ID_ALUOp,
        input  EX_Valid, EX_Dst, EX_Src, EX_Data_Dst, EX_Data_Src, EX_WB,
               EX_MemRead, EX_MemWrite, EX_ALUOp, Stall, Bubble_Count
    );

    modport slave (
        input  Hold, Flush, ID_Valid, ID_Dst, ID_Src, ID_UsesDst, ID_UsesSrc,
               ID_Data_Dst, ID_Data_Src, ID_WB, ID_MemRead, ID_MemWrite, ID_ALUOp,
        output EX_Valid, EX_Dst, EX_Src, EX_Data_Dst, EX_Data_Src, EX_WB,
               EX_MemRead, EX_MemWrite, EX_ALUOp, Stall, Bubble_Count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and deferred flush
module id_ex_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic    clk,
    input  logic    rst,
    id_ex_if.slave  bus
);
    typedef enum logic {RUN, FLUSH_PEND} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_valid, r_wb, r_mem_read, r_mem_write;
    logic [REG_W-1:0]   r_dst, r_src;
    logic [DATA_W-1:0]  r_data_dst, r_data_src;
    logic [ALUOP_W-1:0] r_alu_op;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic               w_flush_eff, w_hazard, w_bubble, w_id_wb, w_id_mr, w_id_mw;

    assign w_flush_eff = bus.Flush | (r_state == FLUSH_PEND);
    assign w_hazard    = r_valid & r_mem_read & r_wb & bus.ID_Valid &
                         ((bus.ID_UsesDst & (bus.ID_Dst == r_dst)) |
                          (bus.ID_UsesSrc & (bus.ID_Src == r_dst)));
    assign w_bubble    = w_flush_eff | w_hazard;
    assign w_id_wb     = bus.ID_WB & bus.ID_Valid;
    assign w_id_mr     = bus.ID_MemRead & bus.ID_Valid;
    assign w_id_mw     = bus.ID_MemWrite & bus.ID_Valid;

    // A flush seen while held is remembered and consumed on the first unheld edge
    always_comb begin
        w_state_nxt = bus.Hold ? (bus.Flush ? FLUSH_PEND : r_state) : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_wb         <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_dst        <= '0;
            r_src        <= '0;
            r_data_dst   <= '0;
            r_data_src   <= '0;
            r_alu_op     <= '0;
            r_bubble_cnt <= '0;
        end else if (!bus.Hold) begin
            r_valid     <= w_bubble ? 1'b0 : bus.ID_Valid;
            r_wb        <= w_bubble ? 1'b0 : w_id_wb;
            r_mem_read  <= w_bubble ? 1'b0 : w_id_mr;
            r_mem_write <= w_bubble ? 1'b0 : w_id_mw;
            r_dst       <= w_bubble ? '0 : bus.ID_Dst;
            r_src       <= w_bubble ? '0 : bus.ID_Src;
            r_data_dst  <= w_bubble ? '0 : bus.ID_Data_Dst;
            r_data_src  <= w_bubble ? '0 : bus.ID_Data_Src;
            r_alu_op    <= w_bubble ? '0 : bus.ID_ALUOp;
            if (w_hazard && !w_flush_eff && !(&r_bubble_cnt))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bus.Stall        = w_hazard & ~bus.Hold & ~w_flush_eff & ~rst;
    assign bus.EX_Valid     = r_valid;
    assign bus.EX_Dst       = r_dst;
    assign bus.EX_Src       = r_src;
    assign bus.EX_Data_Dst  = r_data_dst;
    assign bus.EX_Data_Src  = r_data_src;
    assign bus.EX_WB        = r_wb;
    assign bus.EX_MemRead   = r_mem_read;
    assign bus.EX_MemWrite  = r_mem_write;
    assign bus.EX_ALUOp     = r_alu_op;
    assign bus.Bubble_Count = r_bubble_cnt;
endmodule
